// File: rtl/motion_pkg.sv
// Shared motion types and default playfield geometry for the player sprite path.
package motion_pkg;

  localparam int unsigned POS_W   = 10;
  localparam int unsigned ARITH_W = 11;

  localparam int unsigned X_MIN_DEF   = 0;
  localparam int unsigned X_MAX_DEF   = 639;
  localparam int unsigned Y_MIN_DEF   = 0;
  localparam int unsigned Y_MAX_DEF   = 479;
  localparam int unsigned X_START_DEF = 320;
  localparam int unsigned Y_START_DEF = 240;
  localparam int unsigned STEP_DEF    = 2;
  localparam int unsigned SIZE_DEF    = 16;

  typedef enum logic [1:0] {
    DIR_W = 2'd0,
    DIR_A = 2'd1,
    DIR_S = 2'd2,
    DIR_D = 2'd3
  } dir_t;

  // Encoded so that bit 1 reads as Moving and bit 0 as AtWall.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    MOVING  = 2'b10,
    BLOCKED = 2'b11
  } move_state_t;

  typedef logic signed [ARITH_W-1:0] coord_t;

  typedef struct packed {
    logic [POS_W-1:0] x;
    logic [POS_W-1:0] y;
  } pos_t;

  function automatic coord_t clamp_coord(input coord_t v, input coord_t lo, input coord_t hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/edge_detect_rise.sv
// Rising-edge strobe for slow level signals; stays quiet until the input has
// been seen low after reset, so a level already high at reset release is ignored.
module edge_detect_rise (
  input  logic Clk,
  input  logic Reset,
  input  logic in,
  output logic pulse
);

  logic in_d;
  logic armed;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      in_d  <= 1'b0;
      armed <= 1'b0;
    end else begin
      in_d <= in;
      if (!in) armed <= 1'b1;
    end
  end

  assign pulse = in & ~in_d & armed;

endmodule

// File: rtl/player_motion.sv
// Player sprite position tracker: latches keyboard motion commands and applies
// one clamped step per frame tick.
module player_motion
  import motion_pkg::*;
#(
  parameter int unsigned X_MIN   = X_MIN_DEF,
  parameter int unsigned X_MAX   = X_MAX_DEF,
  parameter int unsigned Y_MIN   = Y_MIN_DEF,
  parameter int unsigned Y_MAX   = Y_MAX_DEF,
  parameter int unsigned X_START = X_START_DEF,
  parameter int unsigned Y_START = Y_START_DEF,
  parameter int unsigned STEP    = STEP_DEF,
  parameter int unsigned SIZE    = SIZE_DEF
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             frame_clk,
  input  logic [1:0]       motionFlag,
  input  logic             Load,
  output logic [POS_W-1:0] PosX,
  output logic [POS_W-1:0] PosY,
  output logic [1:0]       Dir,
  output logic             Moving,
  output logic             AtWall
);

  localparam coord_t X_LO   = coord_t'(X_MIN);
  localparam coord_t X_HI   = coord_t'(X_MAX - SIZE + 1);
  localparam coord_t Y_LO   = coord_t'(Y_MIN);
  localparam coord_t Y_HI   = coord_t'(Y_MAX - SIZE + 1);
  localparam coord_t STEP_C = coord_t'(STEP);

  logic        tick;
  logic        pending;
  dir_t        cmd_dir;
  move_state_t state;

  logic        cmd_valid;
  dir_t        eff_dir;
  logic        axis_y;
  coord_t      base;
  coord_t      delta;
  coord_t      lo;
  coord_t      hi;
  coord_t      raw;
  coord_t      stepped;
  logic        clamped;
  pos_t        nxt_pos;
  move_state_t next_state;

  edge_detect_rise u_frame_edge (
    .Clk   (Clk),
    .Reset (Reset),
    .in    (frame_clk),
    .pulse (tick)
  );

  // Step arithmetic in signed 11-bit so a step past either edge cannot wrap.
  always_comb begin
    eff_dir    = Load ? dir_t'(motionFlag) : cmd_dir;
    cmd_valid  = Load | pending;
    axis_y     = (eff_dir == DIR_W) || (eff_dir == DIR_S);
    base       = axis_y ? coord_t'({1'b0, PosY}) : coord_t'({1'b0, PosX});
    lo         = axis_y ? Y_LO : X_LO;
    hi         = axis_y ? Y_HI : X_HI;
    delta      = ((eff_dir == DIR_W) || (eff_dir == DIR_A)) ? -STEP_C : STEP_C;
    raw        = base + delta;
    stepped    = clamp_coord(raw, lo, hi);
    clamped    = (stepped != raw);
    nxt_pos.x  = PosX;
    nxt_pos.y  = PosY;
    if (axis_y) nxt_pos.y = POS_W'(stepped);
    else        nxt_pos.x = POS_W'(stepped);
    next_state = !cmd_valid ? IDLE : (clamped ? BLOCKED : MOVING);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      PosX    <= POS_W'(X_START);
      PosY    <= POS_W'(Y_START);
      Dir     <= 2'b00;
      pending <= 1'b0;
      cmd_dir <= DIR_W;
      state   <= IDLE;
    end else begin
      // A Load on the tick cycle re-arms pending so a held key keeps moving.
      if (Load) begin
        pending <= 1'b1;
        cmd_dir <= dir_t'(motionFlag);
      end else if (tick) begin
        pending <= 1'b0;
      end
      if (tick) begin
        state <= next_state;
        if (cmd_valid) begin
          PosX <= nxt_pos.x;
          PosY <= nxt_pos.y;
          Dir  <= eff_dir;
        end
      end
    end
  end

  assign Moving = state[1];
  assign AtWall = state[0];

endmodule

// File: tb/tb_player_motion.sv
// Scoreboard bench for player_motion: three instances with different start X
// share stimulus; expected frame results are queued and checked by a monitor.
module tb_player_motion;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic       Load;
  logic [1:0] motionFlag;

  logic [9:0] px   [3];
  logic [9:0] py   [3];
  logic [1:0] dir  [3];
  logic       mov  [3];
  logic       wall [3];

  always #5 Clk = ~Clk;

  player_motion dut0 (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .motionFlag(motionFlag), .Load(Load),
    .PosX(px[0]), .PosY(py[0]), .Dir(dir[0]), .Moving(mov[0]), .AtWall(wall[0])
  );

  player_motion #(.X_START(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .motionFlag(motionFlag), .Load(Load),
    .PosX(px[1]), .PosY(py[1]), .Dir(dir[1]), .Moving(mov[1]), .AtWall(wall[1])
  );

  player_motion #(.X_START(623)) dut2 (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .motionFlag(motionFlag), .Load(Load),
    .PosX(px[2]), .PosY(py[2]), .Dir(dir[2]), .Moving(mov[2]), .AtWall(wall[2])
  );

  typedef struct {
    int due;
    int unit;
    int x;
    int y;
    int d;
    int m;
    int w;
  } exp_t;

  exp_t sb[$];
  exp_t stage[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int unit, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s unit%0d got %0d expected %0d (cycle %0d)", name, unit, act, want, cyc);
    end
  endfunction

  function automatic void check_unit(input string tag, input int u, input int x, input int y,
                                     input int d, input int m, input int w);
    chk({tag, ".PosX"},   u, int'(px[u]),   x);
    chk({tag, ".PosY"},   u, int'(py[u]),   y);
    chk({tag, ".Dir"},    u, int'(dir[u]),  d);
    chk({tag, ".Moving"}, u, int'(mov[u]),  m);
    chk({tag, ".AtWall"}, u, int'(wall[u]), w);
  endfunction

  // Monitor: compares each queued expectation one clock after it was issued.
  always @(negedge Clk) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      exp_t e;
      e = sb.pop_front();
      if (e.due < cyc) begin
        checks++;
        errors++;
        $display("FAIL stale_entry unit%0d due %0d seen at %0d", e.unit, e.due, cyc);
      end else begin
        check_unit("frame", e.unit, e.x, e.y, e.d, e.m, e.w);
      end
    end
  end

  task automatic expect_st(input int u, input int x, input int y, input int d, input int m, input int w);
    exp_t e;
    e = '{0, u, x, y, d, m, w};
    stage.push_back(e);
  endtask

  task automatic release_stage();
    foreach (stage[i]) begin
      exp_t e;
      e = stage[i];
      e.due = cyc + 1;
      sb.push_back(e);
    end
    stage.delete();
  endtask

  task automatic do_tick();
    @(negedge Clk);
    frame_clk = 1'b1;
    release_stage();
    @(negedge Clk);
    frame_clk = 1'b0;
    repeat (3) @(negedge Clk);
  endtask

  task automatic pulse_load(input logic [1:0] mf);
    @(negedge Clk);
    motionFlag = mf;
    Load = 1'b1;
    @(negedge Clk);
    Load = 1'b0;
  endtask

  initial begin
    Reset = 1'b1;
    frame_clk = 1'b0;
    Load = 1'b0;
    motionFlag = 2'b00;
    #1;
    check_unit("reset_noclk", 0, 320, 240, 0, 0, 0);
    check_unit("reset_noclk", 1, 1, 240, 0, 0, 0);
    check_unit("reset_noclk", 2, 623, 240, 0, 0, 0);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);

    // Held D across three ticks; unit2 hits the right wall immediately.
    @(negedge Clk);
    motionFlag = 2'b11;
    Load = 1'b1;
    expect_st(0, 322, 240, 3, 1, 0); expect_st(1, 3, 240, 3, 1, 0); expect_st(2, 624, 240, 3, 1, 1);
    do_tick();
    expect_st(0, 324, 240, 3, 1, 0); expect_st(1, 5, 240, 3, 1, 0); expect_st(2, 624, 240, 3, 1, 1);
    do_tick();
    expect_st(0, 326, 240, 3, 1, 0); expect_st(1, 7, 240, 3, 1, 0); expect_st(2, 624, 240, 3, 1, 1);
    do_tick();
    @(negedge Clk);
    Load = 1'b0;
    // Key released: the command latched on the last tick still applies once.
    expect_st(0, 328, 240, 3, 1, 0); expect_st(1, 9, 240, 3, 1, 0); expect_st(2, 624, 240, 3, 1, 1);
    do_tick();
    expect_st(0, 328, 240, 3, 0, 0); expect_st(1, 9, 240, 3, 0, 0); expect_st(2, 624, 240, 3, 0, 0);
    do_tick();

    // Single-cycle W pulse mid-frame.
    pulse_load(2'b00);
    expect_st(0, 328, 238, 0, 1, 0); expect_st(1, 9, 238, 0, 1, 0); expect_st(2, 624, 238, 0, 1, 0);
    do_tick();
    expect_st(0, 328, 238, 0, 0, 0); expect_st(1, 9, 238, 0, 0, 0); expect_st(2, 624, 238, 0, 0, 0);
    do_tick();

    // A then D within one frame: last Load wins.
    pulse_load(2'b01);
    @(negedge Clk);
    pulse_load(2'b11);
    expect_st(0, 330, 238, 3, 1, 0); expect_st(1, 11, 238, 3, 1, 0); expect_st(2, 624, 238, 3, 1, 1);
    do_tick();

    // Mid-frame reset with an S command pending: restore and discard.
    pulse_load(2'b10);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    check_unit("reset_mid", 0, 320, 240, 0, 0, 0);
    @(negedge Clk);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);
    expect_st(0, 320, 240, 0, 0, 0); expect_st(1, 1, 240, 0, 0, 0); expect_st(2, 623, 240, 0, 0, 0);
    do_tick();

    // Held A: unit1 clamps at the left wall.
    @(negedge Clk);
    motionFlag = 2'b01;
    Load = 1'b1;
    expect_st(0, 318, 240, 1, 1, 0); expect_st(1, 0, 240, 1, 1, 1); expect_st(2, 621, 240, 1, 1, 0);
    do_tick();
    expect_st(0, 316, 240, 1, 1, 0); expect_st(1, 0, 240, 1, 1, 1); expect_st(2, 619, 240, 1, 1, 0);
    do_tick();
    @(negedge Clk);
    Load = 1'b0;
    expect_st(0, 314, 240, 1, 1, 0); expect_st(1, 0, 240, 1, 1, 1); expect_st(2, 617, 240, 1, 1, 0);
    do_tick();

    // frame_clk high at reset release: no move until a fresh rising edge.
    @(negedge Clk);
    Reset = 1'b1;
    frame_clk = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    motionFlag = 2'b11;
    Load = 1'b1;
    repeat (3) @(negedge Clk);
    expect_st(0, 320, 240, 0, 0, 0);
    @(negedge Clk);
    release_stage();
    @(negedge Clk);
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
    expect_st(0, 322, 240, 3, 1, 0);
    do_tick();
    Load = 1'b0;

    for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge Clk);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending %0d expected 0", sb.size());
    end
    repeat (2) @(negedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
